// File: rtl/key_sw_reader_pkg.sv
// Shared board constants for the DE0-Nano key/switch input path.
package key_sw_reader_pkg;

  localparam int CONST_50M = 32'd50000000;

  function automatic int ms_to_cycles(input int ms);
    return (CONST_50M / 32'd1000) * ms;
  endfunction

  localparam int DEBOUNCE_20MS = ms_to_cycles(32'd20);
  localparam int DEBOUNCE_SIM  = 32'd8;

endpackage

// File: rtl/key_sw_reader_debounce_cell.sv
// One input bit: synchroniser chain, debounce counter, accepted level and
// registered rise/fall pulses aligned with the level change.
module debounce_cell
  import key_sw_reader_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced_s;

  assign synced_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d   = cnt_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (synced_s == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Pulses are computed here so they appear together with the new level.
      state_d = synced_s;
      cnt_d   = '0;
      rise_d  = synced_s;
      fall_d  = ~synced_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/key_sw_reader.sv
// Debounced pushbutton and DIP-switch reader: clean levels, edge pulses and
// a wrapping press counter for the display/pattern logic.
module key_sw_reader
  import key_sw_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int SYNC_STAGES     = 2,
  parameter int N_SW            = 4,
  parameter int PRESS_CNT_W     = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   KEY,
  input  logic                   KEY_IN,
  input  logic [N_SW-1:0]        SW,
  output logic                   key_level,
  output logic                   key_press,
  output logic                   key_release,
  output logic [N_SW-1:0]        sw_state,
  output logic                   sw_changed,
  output logic [PRESS_CNT_W-1:0] press_count
);

  logic [N_SW:0]            raw_s, level_s, rise_s, fall_s;
  logic [PRESS_CNT_W-1:0]   press_count_q, press_count_d;

  // Button is inverted ahead of its chain, so a chain reset to 0 means "released".
  assign raw_s = {SW, ~KEY_IN};

  for (genvar i = 0; i <= N_SW; i++) begin : g_cell
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i  (CLOCK_50),
      .rst_ni (KEY),
      .raw_i  (raw_s[i]),
      .level_o(level_s[i]),
      .rise_o (rise_s[i]),
      .fall_o (fall_s[i])
    );
  end

  assign key_level   = level_s[0];
  assign key_press   = rise_s[0];
  assign key_release = fall_s[0];
  assign sw_state    = level_s[N_SW:1];
  assign sw_changed  = |(rise_s[N_SW:1] | fall_s[N_SW:1]);

  always_comb begin
    if (key_press) begin
      press_count_d = press_count_q + PRESS_CNT_W'(1);
    end else begin
      press_count_d = press_count_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      press_count_q <= '0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign press_count = press_count_q;

endmodule

// File: tb/tb_key_sw_reader.sv
// Self-checking bench for key_sw_reader with an 8-cycle debounce window.
module tb_key_sw_reader;

  localparam int DEB  = 8;
  localparam int SYNC = 2;

  logic       CLOCK_50 = 1'b0;
  logic       KEY;
  logic       KEY_IN;
  logic [3:0] SW;
  logic       key_level, key_press, key_release, sw_changed;
  logic [3:0] sw_state;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;

  // Reference: a level flips once the last DEB synchronised samples all disagree with it.
  logic [4:0] m_hist[$];
  logic [4:0] m_lvl;
  logic       m_kp, m_kr, m_swc;
  int         m_cnt;

  typedef struct {
    logic       key_in;
    logic [3:0] sw;
    int         hold;
    logic       exp_level;
    logic [3:0] exp_sw;
  } vec_t;
  vec_t vecs[10];

  key_sw_reader #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .N_SW(4), .PRESS_CNT_W(8)) dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .KEY_IN(KEY_IN), .SW(SW),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .sw_state(sw_state), .sw_changed(sw_changed), .press_count(press_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (16) m_hist.push_back(5'b0);
    m_lvl = 5'b0; m_kp = 1'b0; m_kr = 1'b0; m_swc = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [4:0] v);
    logic [4:0] flip;
    bit all;
    if (m_kp) m_cnt = (m_cnt + 1) % 256;
    for (int b = 0; b < 5; b++) begin
      all = 1'b1;
      for (int i = SYNC - 1; i <= SYNC - 2 + DEB; i++)
        if (m_hist[i][b] == m_lvl[b]) all = 1'b0;
      flip[b] = all;
    end
    m_lvl = m_lvl ^ flip;
    m_kp  = flip[0] & m_lvl[0];
    m_kr  = flip[0] & ~m_lvl[0];
    m_swc = |flip[4:1];
    m_hist.push_front(v);
    while (m_hist.size() > 16) void'(m_hist.pop_back());
  endtask

  task automatic compare_all();
    check("model_key_level",   32'(key_level),   32'(m_lvl[0]));
    check("model_key_press",   32'(key_press),   32'(m_kp));
    check("model_key_release", 32'(key_release), 32'(m_kr));
    check("model_sw_state",    32'(sw_state),    32'(m_lvl[4:1]));
    check("model_sw_changed",  32'(sw_changed),  32'(m_swc));
    check("model_press_count", 32'(press_count), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    if (!KEY) model_reset();
    else model_step({SW, ~KEY_IN});
    @(negedge CLOCK_50);
    compare_all();
  endtask

  task automatic async_reset();
    KEY = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_async_zero", 32'({key_level, key_press, key_release, sw_state, sw_changed, press_count}), 32'd0);
  endtask

  initial begin
    int np, nr, nc, at;
    vecs[0] = '{1'b1, 4'b0101, 12, 1'b0, 4'b0101};
    vecs[1] = '{1'b0, 4'b1010,  5, 1'b0, 4'b0101};
    vecs[2] = '{1'b1, 4'b0101, 12, 1'b0, 4'b0101};
    vecs[3] = '{1'b0, 4'b1111, 10, 1'b1, 4'b1111};
    vecs[4] = '{1'b0, 4'b1111,  3, 1'b1, 4'b1111};
    vecs[5] = '{1'b1, 4'b0000,  9, 1'b1, 4'b1111};
    vecs[6] = '{1'b1, 4'b0000,  1, 1'b0, 4'b0000};
    vecs[7] = '{1'b0, 4'b1000,  7, 1'b0, 4'b0000};
    vecs[8] = '{1'b1, 4'b0000, 12, 1'b0, 4'b0000};
    vecs[9] = '{1'b0, 4'b0011, 20, 1'b1, 4'b0011};

    // 1: reset with button pressed and all switches on
    KEY = 1'b0; KEY_IN = 1'b0; SW = 4'hF;
    model_reset();
    @(negedge CLOCK_50);
    repeat (3) begin
      tick();
      check("reset_outputs", 32'({key_level, key_press, key_release, sw_state, sw_changed, press_count}), 32'd0);
    end
    KEY = 1'b1; KEY_IN = 1'b1; SW = 4'h0;
    repeat (12) tick();

    // 2: clean press, then release
    KEY_IN = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("press_level", 32'(key_level), 32'(e >= 10));
      check("press_pulse", 32'(key_press), 32'(e == 10));
      check("press_count", 32'(press_count), 32'(e >= 11));
    end
    KEY_IN = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("release_pulse", 32'(key_release), 32'(e == 10));
    end

    // 3: bouncing press
    np = 0;
    KEY_IN = 1'b0; repeat (5) begin tick(); np += int'(key_press); end
    KEY_IN = 1'b1; repeat (2) begin tick(); np += int'(key_press); end
    KEY_IN = 1'b0; repeat (5) begin tick(); np += int'(key_press); end
    KEY_IN = 1'b1; repeat (3) begin tick(); np += int'(key_press); end
    check("bounce_early_press", 32'(np), 32'd0);
    KEY_IN = 1'b0; at = 0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (key_press) begin np++; at = e; end
    end
    check("bounce_press_count", 32'(np), 32'd1);
    check("bounce_press_edge", 32'(at), 32'd10);
    KEY_IN = 1'b1;
    repeat (12) tick();

    // 4: 256 press/release pairs wrap the counter
    async_reset();
    tick();
    KEY = 1'b1;
    np = 0; nr = 0;
    for (int p = 0; p < 256; p++) begin
      KEY_IN = 1'b0;
      repeat (11) begin tick(); np += int'(key_press); nr += int'(key_release); end
      KEY_IN = 1'b1;
      repeat (11) begin tick(); np += int'(key_press); nr += int'(key_release); end
      if (p == 254) check("wrap_count_255", 32'(press_count), 32'd255);
    end
    check("wrap_presses", 32'(np), 32'd256);
    check("wrap_releases", 32'(nr), 32'd256);
    check("wrap_count_0", 32'(press_count), 32'd0);

    // 5: switches change together, then a short glitch on SW[3]
    SW = 4'b0101; nc = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("sw_state_step", 32'(sw_state), (e >= 10) ? 32'h5 : 32'h0);
      check("sw_changed_step", 32'(sw_changed), 32'(e == 10));
    end
    SW = 4'b1101; repeat (3) begin tick(); nc += int'(sw_changed); end
    SW = 4'b0101; repeat (12) begin tick(); nc += int'(sw_changed); end
    check("sw_glitch_pulses", 32'(nc), 32'd0);
    check("sw_glitch_state", 32'(sw_state), 32'h5);

    // 6: reset on the 5th cycle of a press debounce
    KEY_IN = 1'b0;
    repeat (4) tick();
    async_reset();
    repeat (2) tick();
    KEY = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("rst_mid_level", 32'(key_level), 32'(e >= 10));
      check("rst_mid_press", 32'(key_press), 32'(e == 10));
    end

    // Table-driven segments
    for (int v = 0; v < 10; v++) begin
      KEY_IN = vecs[v].key_in; SW = vecs[v].sw;
      repeat (vecs[v].hold) tick();
      check($sformatf("vec%0d_level", v), 32'(key_level), 32'(vecs[v].exp_level));
      check($sformatf("vec%0d_sw", v), 32'(sw_state), 32'(vecs[v].exp_sw));
    end

    // Randomised segments with occasional resets, checked against the model every cycle
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset();
        tick();
        KEY = 1'b1;
      end
      KEY_IN = 1'($urandom);
      SW = 4'($urandom);
      repeat ($urandom_range(1, 14)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
